mem_wb_pipe: RTL

Parametrised MEM→WB pipeline stage for the scalar and dual-issue cores. It registers up to `LANES` register-file writes plus one HI/LO write per cycle, and decouples MEM from WB with a valid/ready handshake and a one-entry skid slot. It also supports global stall and flush, and suppresses writes to r0. It replaces the fixed-width, stall-only MEM/WB register and sits between the MEM stage and the register-file/HI-LO write ports.

---
 rtl/mem_wb_pkg.sv | 13 +
 rtl/mem_wb_slot.sv | 30 +++
 rtl/mem_wb_pipe.sv | 60 ++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared defaults, entry-width helper and r0 write filter for the MEM/WB stage.
package mem_wb_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 5;
  localparam int DEF_LANES = 1;
  localparam int MAX_AW = 16;
  function automatic int entry_w(input int dw, input int aw, input int lanes);
    return lanes * (1 + aw + dw) + 1 + 2 * dw;
  endfunction
  function automatic logic r0_filter(input logic we, input logic [MAX_AW-1:0] addr);
    return we && (addr != '0);
  endfunction
endpackage

// File: rtl/mem_wb_slot.sv
// mem_wb_slot: one pipeline entry register with valid flag, load and clear (clear wins).
module mem_wb_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  logic valid_d, valid_q;
  logic [W-1:0] data_d, data_q;
  always_comb begin
    valid_d = clr ? 1'b0 : load ? 1'b1 : valid_q;
    data_d = load ? d : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign valid = valid_q;
  assign q = data_q;
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB register stage with valid/ready handshake, one-entry skid slot, stall, flush and r0 filter.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int LANES = DEF_LANES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [LANES-1:0]    mem_we,
  input  logic [LANES*AW-1:0] mem_waddr,
  input  logic [LANES*DW-1:0] mem_wdata,
  input  logic                mem_whilo,
  input  logic [DW-1:0]       mem_hi,
  input  logic [DW-1:0]       mem_lo,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [LANES-1:0]    wb_we,
  output logic [LANES*AW-1:0] wb_waddr,
  output logic [LANES*DW-1:0] wb_wdata,
  output logic                wb_whilo,
  output logic [DW-1:0]       wb_hi,
  output logic [DW-1:0]       wb_lo,
  output logic                wb_pending
);
  localparam int EW = entry_w(DW, AW, LANES);
  logic [EW-1:0] new_e, out_e, skid_e;
  logic [LANES-1:0] we_f, o_we;
  logic o_whilo, out_v, skid_v, push, pop, out_load, out_clr, skid_load, skid_clr;
  always_comb begin
    for (int i = 0; i < LANES; i++) we_f[i] = r0_filter(mem_we[i], MAX_AW'(mem_waddr[i*AW +: AW]));
    new_e = {we_f, mem_waddr, mem_wdata, mem_whilo, mem_hi, mem_lo};
    mem_ready = !reset && !skid_v && !stall;
    push = mem_valid && mem_ready && !flush;
    pop = out_v && wb_ready && !stall && !flush;
    // SKID is never bypassed: while it holds an entry OUT refills only from it
    out_load = (pop && skid_v) || (push && (!out_v || pop));
    out_clr = flush || (pop && !skid_v && !push);
    skid_load = push && out_v && !pop;
    skid_clr = flush || pop;
  end
  mem_wb_slot #(.W(EW)) u_out (
    .clk(clk), .reset(reset), .load(out_load), .clr(out_clr),
    .d(skid_v ? skid_e : new_e), .valid(out_v), .q(out_e)
  );
  mem_wb_slot #(.W(EW)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .clr(skid_clr),
    .d(new_e), .valid(skid_v), .q(skid_e)
  );
  assign {o_we, wb_waddr, wb_wdata, o_whilo, wb_hi, wb_lo} = out_e;
  assign wb_valid = out_v;
  assign wb_we = o_we & {LANES{out_v}};
  assign wb_whilo = o_whilo & out_v;
  assign wb_pending = skid_v;
endmodule
